frame_config_sequencer: RTL and testbench
=========================================

FRAME_CONFIG_SEQUENCER -- requirements
Module: frame_config_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter COORD_W, default 13, meaning row/col width.
REQ-004 SHALL have parameter THRESH_WIDTH, default 9, meaning signed width of each chroma target/threshold entry.
REQ-005 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-006 SHALL have port reset_n, input, 1, meaning reset, synchronous, active-low.
REQ-007 SHALL have port pix_valid, input, 1, meaning one pixel accepted this cycle.
REQ-008 SHALL have port frame_sync, input, 1, meaning soft realign of the raster to frame start.
REQ-009 SHALL have port cfg_wr_valid, input, 1, meaning a config write request.
REQ-010 SHALL have port cfg_wr_ready, output, 1, meaning the write is accepted when both valid and ready are high.
REQ-011 SHALL have port cfg_addr, input, 3, meaning entry index: 0 uTarget1, 1 vTarget1, 2 uThresh1, 3 vThresh1, 4 uTarget2, 5 vTarget2, 6 uThresh2, 7 vThresh2.
REQ-012 SHALL have port cfg_data, input, THRESH_WIDTH, meaning signed entry value.
REQ-013 SHALL have port row, output, COORD_W, meaning the line of the pixel presented with pix_valid.
REQ-014 SHALL have port col, output, COORD_W, meaning the column of that pixel.
REQ-015 SHALL have ports sof, eol and eof, each output, 1, meaning first pixel of frame, last pixel of line and last pixel of frame.
REQ-016 SHALL have port frame_count, output, 16, meaning completed frames.
REQ-017 SHALL have port cfg_active, output, 8*THRESH_WIDTH, meaning the live config; entry i occupies bits [i*THRESH_WIDTH +: THRESH_WIDTH].
REQ-018 SHALL have port cfg_pending, output, 1, meaning the shadow bank differs from the active bank and is uncommitted.

Function
REQ-019 row/col SHALL be registered counters; on each pix_valid, col SHALL increment; at col==WIDTH-1 col SHALL wrap to 0 and row SHALL increment; at row==HEIGHT-1 with that wrap, row SHALL wrap to 0.
REQ-020 sof, eol and eof SHALL be combinational and qualified by pix_valid: sof at (0,0), eol at col==WIDTH-1, eof at (HEIGHT-1, WIDTH-1).
REQ-021 The FSM states SHALL be IDLE (reset or after frame_sync) and STREAM; IDLE SHALL go to STREAM on pix_valid; STREAM SHALL go to IDLE on frame_sync.
REQ-022 frame_sync SHALL take priority over pix_valid: row and col SHALL go to 0 next cycle, the partial frame SHALL NOT increment frame_count, and no commit SHALL occur.
REQ-023 cfg_wr_ready SHALL be 1 in all states except the single cycle after reset release, where it SHALL be 0.
REQ-024 An accepted write SHALL update shadow[cfg_addr] next cycle and SHALL set cfg_pending.
REQ-025 In IDLE, an accepted write SHALL also update the active entry next cycle, and cfg_pending SHALL stay 0.
REQ-026 In STREAM, the active bank SHALL change only on the eof cycle: active <= shadow and cfg_pending <= 0, visible from the next frame's first pixel.
REQ-027 A write accepted in the eof cycle SHALL be merged into that commit.
REQ-028 If multiple writes hit the same address before a commit, the last write SHALL win.
REQ-029 frame_count SHALL increment on eof and SHALL wrap from 0xFFFF to 0.

Reset
REQ-030 While reset_n is low at a clk edge, row=0, col=0, frame_count=0, state=IDLE, cfg_pending=0 and cfg_wr_ready=0 SHALL hold.
REQ-031 On reset, active and shadow SHALL both load uTarget1=-26, vTarget1=0, uThresh1=5, vThresh1=5, uTarget2=0, vTarget2=1, uThresh2=5, vThresh2=5.
REQ-032 reset_n low mid-frame SHALL discard the frame and the pending shadow contents.

Structure
REQ-033 The cfg address enum, entry count (8) and reset-default constants SHALL live in a shared package, paddle_cfg_pkg.
REQ-034 The raster counter with its sof/eol/eof decode SHALL be one sub-module, raster_counter, reusable by testbenches.

Verification
REQ-035 Reset, then stream 307200 pixels with pix_valid=1 → eof at row 479, col 639, frame_count=1, row/col=0/0 next cycle.
REQ-036 In STREAM at row 100, write addr0=-20 → cfg_pending=1, cfg_active entry0 stays -26 until after eof, then reads -20 and cfg_pending=0.
REQ-037 Write addr2=7 in the eof cycle → the commit carries uThresh2... correction: the commit carries entry2=7 and cfg_pending=0.
REQ-038 In IDLE, write addr5=3 → cfg_active entry5=3 one cycle later and cfg_pending stays 0.
REQ-039 Assert frame_sync at row 200, col 17 → row/col=0/0, frame_count unchanged, pending write not committed, state IDLE.
REQ-040 Stream with pix_valid toggling 50% and force frame_count to 0xFFFF → eof wraps it to 0, and counters advance only on valid cycles.

Source files
------------

// File: rtl/paddle_cfg_pkg.sv
// rtl/paddle_cfg_pkg.sv - shared config addresses, entry count and reset defaults
package paddle_cfg_pkg;

    localparam int CFG_ENTRIES = 8;

    typedef enum logic [2:0] {
        CFG_U_TARGET1 = 3'd0,
        CFG_V_TARGET1 = 3'd1,
        CFG_U_THRESH1 = 3'd2,
        CFG_V_THRESH1 = 3'd3,
        CFG_U_TARGET2 = 3'd4,
        CFG_V_TARGET2 = 3'd5,
        CFG_U_THRESH2 = 3'd6,
        CFG_V_THRESH2 = 3'd7
    } cfg_addr_e;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } seq_state_e;

    localparam int DEF_U_TARGET1 = -26;
    localparam int DEF_V_TARGET1 = 0;
    localparam int DEF_U_THRESH1 = 5;
    localparam int DEF_V_THRESH1 = 5;
    localparam int DEF_U_TARGET2 = 0;
    localparam int DEF_V_TARGET2 = 1;
    localparam int DEF_U_THRESH2 = 5;
    localparam int DEF_V_THRESH2 = 5;

    function automatic int cfg_default(input logic [2:0] idx);
        int v;
        case (cfg_addr_e'(idx))
            CFG_U_TARGET1: v = DEF_U_TARGET1;
            CFG_V_TARGET1: v = DEF_V_TARGET1;
            CFG_U_THRESH1: v = DEF_U_THRESH1;
            CFG_V_THRESH1: v = DEF_V_THRESH1;
            CFG_U_TARGET2: v = DEF_U_TARGET2;
            CFG_V_TARGET2: v = DEF_V_TARGET2;
            CFG_U_THRESH2: v = DEF_U_THRESH2;
            default:       v = DEF_V_THRESH2;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - row/col raster position with sof/eol/eof decode
module raster_counter #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic               frame_sync,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               sof,
    output logic               eol,
    output logic               eof
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic               last_col;
    logic               last_row;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    // frame_sync wins over a coincident pixel
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (frame_sync) begin
            row_d = '0;
            col_d = '0;
        end else if (pix_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + COORD_W'(1);
            end else begin
                col_d = col_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;
    assign sof = pix_valid && (row_q == '0) && (col_q == '0);
    assign eol = pix_valid && last_col;
    assign eof = pix_valid && last_col && last_row;

endmodule

// File: rtl/frame_config_sequencer.sv
// rtl/frame_config_sequencer.sv - raster sequencer with frame-aligned shadow/active config banks
module frame_config_sequencer
    import paddle_cfg_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int COORD_W      = 13,
    parameter int THRESH_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pix_valid,
    input  logic                          frame_sync,
    input  logic                          cfg_wr_valid,
    output logic                          cfg_wr_ready,
    input  logic [2:0]                    cfg_addr,
    input  logic [THRESH_WIDTH-1:0]       cfg_data,
    output logic [COORD_W-1:0]            row,
    output logic [COORD_W-1:0]            col,
    output logic                          sof,
    output logic                          eol,
    output logic                          eof,
    output logic [15:0]                   frame_count,
    output logic [8*THRESH_WIDTH-1:0]     cfg_active,
    output logic                          cfg_pending
);

    seq_state_e              state_q, state_d;
    logic                    ready_q;
    logic                    pending_q, pending_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [THRESH_WIDTH-1:0] active_q [CFG_ENTRIES];
    logic [THRESH_WIDTH-1:0] active_d [CFG_ENTRIES];
    logic [THRESH_WIDTH-1:0] shadow_q [CFG_ENTRIES];
    logic [THRESH_WIDTH-1:0] shadow_d [CFG_ENTRIES];
    logic                    wr_fire;
    logic                    commit;

    raster_counter #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .COORD_W (COORD_W)
    ) u_raster (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .frame_sync (frame_sync),
        .row        (row),
        .col        (col),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof)
    );

    assign wr_fire = cfg_wr_valid && ready_q;
    assign commit  = eof && !frame_sync;

    // Shadow update happens first so an eof-cycle write is folded into the commit
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        if (wr_fire) begin
            shadow_d[cfg_addr] = cfg_data;
            if (state_q == ST_IDLE) begin
                active_d[cfg_addr] = cfg_data;
            end else begin
                pending_d = 1'b1;
            end
        end
        if (commit) begin
            active_d      = shadow_d;
            pending_d     = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
        end
        if (frame_sync) begin
            state_d = ST_IDLE;
        end else if (pix_valid) begin
            state_d = ST_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            pending_q     <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < CFG_ENTRIES; i++) begin
                active_q[i] <= THRESH_WIDTH'(cfg_default(3'(i)));
                shadow_q[i] <= THRESH_WIDTH'(cfg_default(3'(i)));
            end
        end else begin
            state_q       <= state_d;
            ready_q       <= 1'b1;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
        end
    end

    for (genvar g = 0; g < CFG_ENTRIES; g++) begin : g_pack
        assign cfg_active[g*THRESH_WIDTH +: THRESH_WIDTH] = active_q[g];
    end

    assign cfg_wr_ready = ready_q;
    assign cfg_pending  = pending_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb/tb_frame_config_sequencer.sv - directed and random checks against a frame-level reference model
module tb_frame_config_sequencer;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int CW   = 13;
    localparam int TW   = 9;
    localparam int NPIX = W * H;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pix_valid;
    logic              frame_sync;
    logic              cfg_wr_valid;
    logic              cfg_wr_ready;
    logic [2:0]        cfg_addr;
    logic [TW-1:0]     cfg_data;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic              sof;
    logic              eol;
    logic              eof;
    logic [15:0]       frame_count;
    logic [8*TW-1:0]   cfg_active;
    logic              cfg_pending;

    always #5 clk = ~clk;

    frame_config_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .COORD_W      (CW),
        .THRESH_WIDTH (TW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_valid    (pix_valid),
        .frame_sync   (frame_sync),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .row          (row),
        .col          (col),
        .sof          (sof),
        .eol          (eol),
        .eof          (eof),
        .frame_count  (frame_count),
        .cfg_active   (cfg_active),
        .cfg_pending  (cfg_pending)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: linear pixel index within the frame plus the two banks as plain integers
    int dflt [8] = '{-26, 0, 5, 5, 0, 1, 5, 5};
    int m_p;
    int m_fc;
    int m_act [8];
    int m_sh  [8];
    bit m_pend;
    bit m_stream;
    bit m_ready;

    function automatic logic [TW-1:0] ent(input int v);
        return TW'(v);
    endfunction

    function automatic logic [8*TW-1:0] pack(input int a [8]);
        logic [8*TW-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*TW +: TW] = ent(a[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p      = 0;
        m_fc     = 0;
        m_act    = dflt;
        m_sh     = dflt;
        m_pend   = 1'b0;
        m_stream = 1'b0;
        m_ready  = 1'b0;
    endtask

    task automatic model_update();
        bit acc;
        bit at_eof;
        acc    = cfg_wr_valid && m_ready;
        at_eof = pix_valid && (m_p == NPIX - 1);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (acc) begin
                m_sh[cfg_addr] = int'($signed(cfg_data));
                if (!m_stream) m_act[cfg_addr] = int'($signed(cfg_data));
                else           m_pend = 1'b1;
            end
            if (frame_sync) begin
                m_p      = 0;
                m_stream = 1'b0;
            end else begin
                if (at_eof) begin
                    m_act  = m_sh;
                    m_pend = 1'b0;
                    m_fc   = (m_fc + 1) % 65536;
                end
                if (pix_valid) begin
                    m_p      = (m_p + 1) % NPIX;
                    m_stream = 1'b1;
                end
            end
            m_ready = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("sof", 128'(sof), 128'(pix_valid && m_p == 0));
        check("eol", 128'(eol), 128'(pix_valid && (m_p % W) == W - 1));
        check("eof", 128'(eof), 128'(pix_valid && m_p == NPIX - 1));
        check("cfg_wr_ready", 128'(cfg_wr_ready), 128'(m_ready));
        @(posedge clk);
        model_update();
        #1;
        check("row", 128'(row), 128'(m_p / W));
        check("col", 128'(col), 128'(m_p % W));
        check("frame_count", 128'(frame_count), 128'(m_fc));
        check("cfg_pending", 128'(cfg_pending), 128'(m_pend));
        check("cfg_active", 128'(cfg_active), 128'(pack(m_act)));
    endtask

    task automatic advance_to(input int target);
        pix_valid = 1'b1;
        for (int k = 0; k < 2 * NPIX && m_p != target; k++) cycle();
    endtask

    initial begin
        int saved_fc;
        bit saw_eof;
        reset_n      = 1'b0;
        pix_valid    = 1'b0;
        frame_sync   = 1'b0;
        cfg_wr_valid = 1'b0;
        cfg_addr     = 3'd0;
        cfg_data     = '0;
        model_reset();

        repeat (3) cycle();
        check("reset_active", 128'(cfg_active), 128'(pack(dflt)));
        check("reset_ready", 128'(cfg_wr_ready), 128'(0));

        // First cycle after release refuses writes
        reset_n      = 1'b1;
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd5;
        cfg_data     = ent(77);
        cycle();
        check("refused_write", 128'(cfg_active[5*TW +: TW]), 128'(ent(1)));

        // IDLE write goes straight to the active bank
        cfg_data = ent(3);
        cycle();
        cfg_wr_valid = 1'b0;
        check("idle_write_e5", 128'(cfg_active[5*TW +: TW]), 128'(ent(3)));
        check("idle_write_pend", 128'(cfg_pending), 128'(0));

        // Full frame
        pix_valid = 1'b1;
        repeat (NPIX - 1) cycle();
        check("last_row", 128'(row), 128'(H - 1));
        check("last_col", 128'(col), 128'(W - 1));
        check("eof_comb", 128'(eof), 128'(1));
        cycle();
        check("frame1_count", 128'(frame_count), 128'(1));
        check("frame1_rowcol", 128'({row, col}), 128'(0));

        // Streaming write is held in shadow until eof
        advance_to(2 * W);
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd0;
        cfg_data     = ent(-20);
        cycle();
        cfg_wr_valid = 1'b0;
        check("stream_pend", 128'(cfg_pending), 128'(1));
        check("stream_hold_e0", 128'(cfg_active[0 +: TW]), 128'(ent(-26)));
        advance_to(NPIX - 1);
        check("pre_eof_hold_e0", 128'(cfg_active[0 +: TW]), 128'(ent(-26)));
        cycle();
        check("commit_e0", 128'(cfg_active[0 +: TW]), 128'(ent(-20)));
        check("commit_pend", 128'(cfg_pending), 128'(0));

        // Write in the eof cycle joins the commit
        advance_to(NPIX - 1);
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd2;
        cfg_data     = ent(7);
        cycle();
        cfg_wr_valid = 1'b0;
        check("eof_merge_e2", 128'(cfg_active[2*TW +: TW]), 128'(ent(7)));
        check("eof_merge_pend", 128'(cfg_pending), 128'(0));

        // frame_sync mid-frame with a pending write
        advance_to(W);
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd1;
        cfg_data     = ent(9);
        cycle();
        cfg_wr_valid = 1'b0;
        advance_to(3 * W + 5);
        saved_fc   = m_fc;
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        pix_valid  = 1'b0;
        check("sync_rowcol", 128'({row, col}), 128'(0));
        check("sync_count", 128'(frame_count), 128'(saved_fc));
        check("sync_no_commit", 128'(cfg_active[1*TW +: TW]), 128'(ent(0)));
        check("sync_pend", 128'(cfg_pending), 128'(1));
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd3;
        cfg_data     = ent(-4);
        cycle();
        cfg_wr_valid = 1'b0;
        check("sync_idle_e3", 128'(cfg_active[3*TW +: TW]), 128'(ent(-4)));

        // Random traffic
        for (int k = 0; k < 1200; k++) begin
            pix_valid    = 1'($urandom_range(0, 1));
            frame_sync   = ($urandom_range(0, 199) == 0);
            cfg_wr_valid = ($urandom_range(0, 5) == 0);
            cfg_addr     = 3'($urandom);
            cfg_data     = TW'($urandom);
            cycle();
        end
        frame_sync   = 1'b0;
        cfg_wr_valid = 1'b0;

        // frame_count wrap
        pix_valid = 1'b0;
        force dut.frame_count_q = 16'hFFFF;
        m_fc = 65535;
        cycle();
        release dut.frame_count_q;
        cycle();
        saw_eof = 1'b0;
        for (int k = 0; k < 4 * NPIX + 4 && !saw_eof; k++) begin
            bit hit;
            pix_valid = 1'(k % 2);
            hit       = pix_valid && (m_p == NPIX - 1);
            cycle();
            if (hit) saw_eof = 1'b1;
        end
        pix_valid = 1'b0;
        check("wrap_reached", 128'(saw_eof), 128'(1));
        check("wrap_count", 128'(frame_count), 128'(0));

        // Reset mid-frame drops the frame and the pending shadow
        advance_to(20);
        cfg_wr_valid = 1'b1;
        cfg_addr     = 3'd0;
        cfg_data     = ent(50);
        cycle();
        cfg_wr_valid = 1'b0;
        cycle();
        reset_n = 1'b0;
        cycle();
        check("midrst_active", 128'(cfg_active), 128'(pack(dflt)));
        check("midrst_pend", 128'(cfg_pending), 128'(0));
        check("midrst_rowcol", 128'({row, col}), 128'(0));
        reset_n   = 1'b1;
        pix_valid = 1'b1;
        repeat (NPIX + 3) cycle();
        check("post_rst_count", 128'(frame_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
